cordic_phase_gen: RTL and testbench

Upstream angle sequencer for the CORDIC rotator. It is a programmable phase accumulator (NCO) with optional linear chirp, and it issues one 32-bit angle word per cycle for a bounded or continuous burst. It drives the constant Xin/Yin seed, and it delays an issue strobe by the CORDIC pipeline depth so that downstream logic knows exactly which COSout/SINout samples are valid.

---
 rtl/cordic_pkg.sv | 14 +
 rtl/cordic_valid_delay.sv | 24 ++
 rtl/cordic_phase_gen.sv | 117 +++++++++++
 tb/tb_cordic_phase_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and FSM state type for the CORDIC rotator, its angle
// sequencer and their benches.
package cordic_pkg;
  localparam int ANGLE_W        = 32;
  localparam int WIDTH          = 16;
  localparam int CORDIC_LATENCY = 16;
  localparam int X_INIT         = 19429;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/cordic_valid_delay.sv
// Fixed-depth 1-bit shift register: delays the issue strobe by the CORDIC
// pipeline depth so it lines up with the rotated samples.
module cordic_valid_delay #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  output logic pulse_delayed
);

  logic [DEPTH-1:0] stage_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[DEPTH-2:0], pulse};
    end
  end

  assign pulse_delayed = stage_reg[DEPTH-1];

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase accumulator with linear chirp feeding the CORDIC rotator; issues one
// angle per cycle for a bounded or continuous burst and tracks output validity.
module cordic_phase_gen
  import cordic_pkg::*;
#(
  parameter int ANGLE_W = cordic_pkg::ANGLE_W,
  parameter int WIDTH   = cordic_pkg::WIDTH,
  parameter int LATENCY = cordic_pkg::CORDIC_LATENCY,
  parameter int X_INIT  = cordic_pkg::X_INIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [ANGLE_W-1:0] phase_init,
  input  logic [ANGLE_W-1:0] ftw,
  input  logic [ANGLE_W-1:0] ftw_step,
  input  logic [15:0]        n_samples,
  output logic [ANGLE_W-1:0] angle,
  output logic [WIDTH-1:0]   Xin,
  output logic [WIDTH-1:0]   Yin,
  output logic               issue_valid,
  output logic               out_valid,
  output logic [15:0]        sample_idx,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t             state_reg, state_next;
  logic [ANGLE_W-1:0] angle_reg, ftw_cur_reg, ftw_step_reg;
  logic [15:0]        n_cfg_reg, sample_idx_reg;
  logic [CNT_W-1:0]   drain_cnt_reg;
  logic               issue_valid_reg;
  logic               last_sample;

  // The sample currently on angle is the final one of a bounded burst.
  assign last_sample = (n_cfg_reg != 16'd0) && (sample_idx_reg == n_cfg_reg - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (stop || last_sample) state_next = DRAIN;
      DRAIN:   if (drain_cnt_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle_reg       <= '0;
      ftw_cur_reg     <= '0;
      ftw_step_reg    <= '0;
      n_cfg_reg       <= '0;
      sample_idx_reg  <= '0;
      drain_cnt_reg   <= '0;
      issue_valid_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            angle_reg       <= phase_init;
            ftw_cur_reg     <= ftw;
            ftw_step_reg    <= ftw_step;
            n_cfg_reg       <= n_samples;
            sample_idx_reg  <= '0;
            issue_valid_reg <= 1'b1;
          end
        end
        RUN: begin
          if (state_next == DRAIN) begin
            issue_valid_reg <= 1'b0;
            drain_cnt_reg   <= CNT_W'(LATENCY - 1);
          end else begin
            angle_reg       <= angle_reg + ftw_cur_reg;
            ftw_cur_reg     <= ftw_cur_reg + ftw_step_reg;
            sample_idx_reg  <= sample_idx_reg + 16'd1;
            issue_valid_reg <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt_reg != '0) drain_cnt_reg <= drain_cnt_reg - 1'b1;
        end
        default: issue_valid_reg <= 1'b0;
      endcase
    end
  end

  cordic_valid_delay #(
    .DEPTH (LATENCY)
  ) u_valid_delay (
    .clk           (clk),
    .rst           (rst),
    .pulse         (issue_valid_reg),
    .pulse_delayed (out_valid)
  );

  assign angle       = angle_reg;
  assign sample_idx  = sample_idx_reg;
  assign issue_valid = issue_valid_reg;
  assign busy        = (state_reg != IDLE);
  // Last drain cycle coincides with the final delayed valid.
  assign done        = (state_reg == DRAIN) && (drain_cnt_reg == '0);
  assign Xin         = WIDTH'(X_INIT);
  assign Yin         = '0;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed bench for cordic_phase_gen: tone, wrap, chirp, abort, reset and
// single-sample bursts against hand-computed angles and timing.
module tb_cordic_phase_gen;
  import cordic_pkg::*;

  localparam int LAT = CORDIC_LATENCY;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [31:0] phase_init, ftw, ftw_step;
  logic [15:0] n_samples;
  logic [31:0] angle;
  logic [15:0] Xin, Yin;
  logic        issue_valid, out_valid, busy, done;
  logic [15:0] sample_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] ang [0:31];
  logic [15:0] idx [0:31];
  int n_iss, n_out, n_done;
  int first_iss, last_iss, first_out, last_out, done_cyc, stop_cyc;
  bit got_done;
  logic busy_first;

  cordic_phase_gen dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .phase_init  (phase_init),
    .ftw         (ftw),
    .ftw_step    (ftw_step),
    .n_samples   (n_samples),
    .angle       (angle),
    .Xin         (Xin),
    .Yin         (Yin),
    .issue_valid (issue_valid),
    .out_valid   (out_valid),
    .sample_idx  (sample_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic burst(input logic [31:0] p, input logic [31:0] f, input logic [31:0] s,
                       input logic [15:0] n, input int stop_after, input bit start_in_drain);
    n_iss = 0; n_out = 0; n_done = 0;
    first_iss = -1; last_iss = -1; first_out = -1; last_out = -1;
    done_cyc = -1; stop_cyc = -100; got_done = 1'b0; busy_first = 1'b0;
    phase_init = p; ftw = f; ftw_step = s; n_samples = n;
    start = 1'b1;
    tick;
    for (int k = 0; k < 400 && !got_done; k++) begin
      start = 1'b0;
      stop  = 1'b0;
      if (k == 0) busy_first = busy;
      if (issue_valid) begin
        if (n_iss < 32) begin
          ang[n_iss] = angle;
          idx[n_iss] = sample_idx;
        end
        if (n_iss == 0) first_iss = cyc;
        last_iss = cyc;
        n_iss++;
        if (stop_after > 0 && n_iss == stop_after) begin
          stop = 1'b1;
          stop_cyc = cyc;
        end
      end
      if (out_valid) begin
        if (n_out == 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
      if (start_in_drain && cyc == stop_cyc + 3) start = 1'b1;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        got_done = 1'b1;
      end
      if (!got_done) tick;
    end
    chk("timeout", 32'(got_done), 32'd1);
    start = 1'b0;
    stop  = 1'b0;
    $display("burst phase=0x%08h ftw=0x%08h step=0x%08h n=%0d issues=%0d out_valids=%0d done_at=%0d",
             p, f, s, n, n_iss, n_out, done_cyc - first_iss);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    phase_init = '0; ftw = '0; ftw_step = '0; n_samples = '0;
    #2;
    chk("xin_in_reset", 32'(Xin), 32'd19429);
    chk("yin_in_reset", 32'(Yin), 32'd0);
    tick; tick;
    rst = 1'b0;
    tick;
    chk("rst_angle", angle, 32'd0);
    chk("rst_issue", 32'(issue_valid), 32'd0);
    chk("rst_out", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(sample_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Fixed tone
    burst(32'h0, 32'h0100_0000, 32'h0, 16'd4, 0, 1'b0);
    chk("tone_busy_first", 32'(busy_first), 32'd1);
    chk("tone_n_iss", n_iss, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tone_angle%0d", i), ang[i], 32'(i) << 24);
      chk($sformatf("tone_idx%0d", i), 32'(idx[i]), 32'(i));
    end
    chk("tone_contiguous", last_iss - first_iss, 3);
    chk("tone_n_out", n_out, 4);
    chk("tone_out_latency", first_out - first_iss, LAT);
    chk("tone_done_on_last_out", done_cyc, last_out);
    chk("tone_done_latency", done_cyc - last_iss, LAT);
    chk("tone_n_done", n_done, 1);
    tick;
    chk("tone_busy_after_done", 32'(busy), 32'd0);
    chk("tone_done_one_cycle", 32'(done), 32'd0);

    // Wrap, started in the cycle right after busy dropped
    burst(32'hF000_0000, 32'h2000_0000, 32'h0, 16'd3, 0, 1'b0);
    chk("wrap_n_iss", n_iss, 3);
    chk("wrap_angle0", ang[0], 32'hF000_0000);
    chk("wrap_angle1", ang[1], 32'h1000_0000);
    chk("wrap_angle2", ang[2], 32'h3000_0000);
    tick;

    // Chirp
    burst(32'h0, 32'h0, 32'h0010_0000, 16'd4, 0, 1'b0);
    chk("chirp_angle0", ang[0], 32'h0000_0000);
    chk("chirp_angle1", ang[1], 32'h0000_0000);
    chk("chirp_angle2", ang[2], 32'h0010_0000);
    chk("chirp_angle3", ang[3], 32'h0030_0000);
    tick;

    // Abort of a continuous burst, with a stray start during drain
    burst(32'h100, 32'h10, 32'h0, 16'd0, 10, 1'b1);
    chk("abort_n_iss", n_iss, 10);
    chk("abort_n_out", n_out, 10);
    chk("abort_angle9", ang[9], 32'h190);
    chk("abort_idx9", 32'(idx[9]), 32'd9);
    chk("abort_done_latency", done_cyc - stop_cyc, LAT);
    chk("abort_done_on_last_out", done_cyc, last_out);
    tick;
    chk("abort_busy_after", 32'(busy), 32'd0);
    tick; tick;
    chk("abort_no_restart", 32'(issue_valid), 32'd0);

    // Reset mid-run, asserted between edges
    phase_init = 32'h0; ftw = 32'h1; ftw_step = 32'h0; n_samples = 16'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_angle", angle, 32'd0);
    chk("async_rst_issue", 32'(issue_valid), 32'd0);
    chk("async_rst_idx", 32'(sample_idx), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_out", 32'(out_valid), 32'd0);
    chk("async_rst_xin", 32'(Xin), 32'd19429);
    tick;
    rst = 1'b0;
    n_out = 0; n_done = 0; n_iss = 0;
    for (int k = 0; k < 3 * LAT; k++) begin
      tick;
      if (out_valid) n_out++;
      if (done) n_done++;
      if (issue_valid) n_iss++;
    end
    $display("reset mid-run: out_valids=%0d dones=%0d issues=%0d after reset", n_out, n_done, n_iss);
    chk("post_reset_out", n_out, 0);
    chk("post_reset_done", n_done, 0);
    chk("post_reset_issue", n_iss, 0);

    // Single 90-degree sample for the rotator
    burst(32'h4000_0000, 32'h0, 32'h0, 16'd1, 0, 1'b0);
    chk("single_n_iss", n_iss, 1);
    chk("single_angle", ang[0], 32'h4000_0000);
    chk("single_n_out", n_out, 1);
    chk("single_done_on_out", done_cyc, last_out);
    chk("single_xin", 32'(Xin), 32'd19429);
    chk("single_yin", 32'(Yin), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
